// File: rtl/req_gnt_sync_if.sv
// req_gnt_sync_if: clocked boundary between a stimulus agent and a one-bit
// request/grant link. Drives req from agent commands through a fixed-latency
// pipeline, samples gnt through a register chain, and reports grant edges and
// a grant-wait counter with a timeout flag.
module req_gnt_sync_if #(
  parameter int unsigned OUT_DLY = 0,
  parameter int unsigned IN_SYNC = 1,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             drv_req,
  input  logic             drv_req_en,
  input  logic             drv_toggle,
  input  logic             gnt,
  output logic             req,
  output logic             smp_req,
  output logic             smp_gnt,
  output logic             gnt_rise,
  output logic             gnt_fall,
  output logic [CNT_W-1:0] wait_cnt,
  output logic             timeout
);

  // Stage 0 holds the newest accepted target; stage OUT_DLY drives req.
  localparam int unsigned      PIPE_W  = OUT_DLY + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);

  logic [PIPE_W-1:0]  pipe_q;
  logic [PIPE_W-1:0]  pipe_nxt_c;
  logic               tgt_c;
  logic [IN_SYNC-1:0] sync_q;
  logic [IN_SYNC-1:0] sync_nxt_c;
  logic               smp_nxt_c;

  // Drive target selection: explicit value wins over toggle, else hold.
  always_comb begin
    tgt_c = pipe_q[0];
    if (drv_req_en) begin
      tgt_c = drv_req;
    end else if (drv_toggle) begin
      tgt_c = ~pipe_q[0];
    end
  end

  // Next state of the req pipeline: shift toward req, new target enters stage 0.
  always_comb begin
    pipe_nxt_c    = pipe_q << 1;
    pipe_nxt_c[0] = tgt_c;
  end

  // Next state of the gnt sampling chain; its top bit is the next smp_gnt.
  always_comb begin
    sync_nxt_c    = sync_q << 1;
    sync_nxt_c[0] = gnt;
    smp_nxt_c     = sync_nxt_c[IN_SYNC-1];
  end

  // Req pipeline register; every command is kept, none overwritten in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_nxt_c;
    end
  end

  // Gnt sampling chain register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_nxt_c;
    end
  end

  // Grant edge pulses: registered compare of the next smp_gnt with the current one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt_rise <= 1'b0;
      gnt_fall <= 1'b0;
    end else begin
      gnt_rise <= smp_nxt_c & ~sync_q[IN_SYNC-1];
      gnt_fall <= ~smp_nxt_c & sync_q[IN_SYNC-1];
    end
  end

  // Grant-wait counter: counts while requesting without grant, saturates, clears otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (!req || smp_gnt) begin
      wait_cnt <= '0;
    end else if (wait_cnt != CNT_MAX) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  assign req     = pipe_q[OUT_DLY];
  assign smp_req = pipe_q[OUT_DLY];
  assign smp_gnt = sync_q[IN_SYNC-1];
  assign timeout = (wait_cnt >= TO_VAL);

endmodule

// File: tb/tb_req_gnt_sync_if.sv
// Bench for req_gnt_sync_if: three instances with different latencies and
// sampling depths; expected req values are queued when commands are driven
// and retired when their due edge arrives.
module tb_req_gnt_sync_if;

  typedef struct {
    int unsigned due;
    logic        val;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] drv_req = '0;
  logic [2:0] drv_en = '0;
  logic [2:0] drv_tog = '0;
  logic       gnt0 = 1'b0;
  logic       gnt1 = 1'b0;
  logic       gnt2 = 1'b0;
  logic       resp0 = 1'b0;

  logic [2:0] req, smp_req, smp_gnt, gnt_rise, gnt_fall, timeout;
  logic [3:0] wc0;
  logic [7:0] wc1, wc2;

  exp_t        sbq [3][$];
  logic [2:0]  er = '0;
  logic [2:0]  tgt = '0;
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  // Responder for instance 0: grants one cycle after seeing req when enabled.
  always @(posedge clk) gnt0 <= resp0 ? req[0] : 1'b0;

  req_gnt_sync_if #(.OUT_DLY(0), .IN_SYNC(1), .CNT_W(4), .TIMEOUT(10)) u0 (
    .clk(clk), .rst_n(rst_n), .drv_req(drv_req[0]), .drv_req_en(drv_en[0]),
    .drv_toggle(drv_tog[0]), .gnt(gnt0), .req(req[0]), .smp_req(smp_req[0]),
    .smp_gnt(smp_gnt[0]), .gnt_rise(gnt_rise[0]), .gnt_fall(gnt_fall[0]),
    .wait_cnt(wc0), .timeout(timeout[0]));

  req_gnt_sync_if #(.OUT_DLY(2), .IN_SYNC(1), .CNT_W(8), .TIMEOUT(16)) u1 (
    .clk(clk), .rst_n(rst_n), .drv_req(drv_req[1]), .drv_req_en(drv_en[1]),
    .drv_toggle(drv_tog[1]), .gnt(gnt1), .req(req[1]), .smp_req(smp_req[1]),
    .smp_gnt(smp_gnt[1]), .gnt_rise(gnt_rise[1]), .gnt_fall(gnt_fall[1]),
    .wait_cnt(wc1), .timeout(timeout[1]));

  req_gnt_sync_if #(.OUT_DLY(3), .IN_SYNC(2), .CNT_W(8), .TIMEOUT(16)) u2 (
    .clk(clk), .rst_n(rst_n), .drv_req(drv_req[2]), .drv_req_en(drv_en[2]),
    .drv_toggle(drv_tog[2]), .gnt(gnt2), .req(req[2]), .smp_req(smp_req[2]),
    .smp_gnt(smp_gnt[2]), .gnt_rise(gnt_rise[2]), .gnt_fall(gnt_fall[2]),
    .wait_cnt(wc2), .timeout(timeout[2]));

  function automatic int unsigned dly_of(input int k);
    case (k)
      0:       return 0;
      1:       return 2;
      default: return 3;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Set one instance's strobes and queue the req value it must produce.
  task automatic drive(input int k, input logic en, input logic v, input logic tog);
    logic nv;
    drv_en[k]  = en;
    drv_req[k] = v;
    drv_tog[k] = tog;
    if (rst_n && (en || tog)) begin
      nv     = en ? v : ~tgt[k];
      tgt[k] = nv;
      sbq[k].push_back('{due: cyc + 1 + dly_of(k), val: nv});
    end
  endtask

  task automatic idle();
    drv_en  = '0;
    drv_req = '0;
    drv_tog = '0;
  endtask

  // Advance one edge, retire due expectations and check req/smp_req everywhere.
  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        sbq[k].delete();
        tgt[k] = 1'b0;
        er[k]  = 1'b0;
      end
      while (sbq[k].size() > 0 && sbq[k][0].due <= cyc) begin
        er[k] = sbq[k][0].val;
        void'(sbq[k].pop_front());
      end
      chk($sformatf("req%0d@%0d", k, cyc), req[k], er[k]);
      chk($sformatf("smp_req%0d@%0d", k, cyc), smp_req[k], er[k]);
    end
  endtask

  initial begin
    int unsigned e;

    // Reset held 3 edges with every strobe and gnt2 active.
    rst_n   = 1'b0;
    drv_en  = '1;
    drv_req = '1;
    drv_tog = '1;
    gnt1    = 1'b1;
    gnt2    = 1'b1;
    repeat (3) step();
    chk("rst_smp_gnt", 32'(smp_gnt), 32'(0));
    chk("rst_rise", 32'(gnt_rise), 32'(0));
    chk("rst_fall", 32'(gnt_fall), 32'(0));
    chk("rst_timeout", 32'(timeout), 32'(0));
    chk("rst_wc0", 32'(wc0), 32'(0));
    chk("rst_wc1", 32'(wc1), 32'(0));
    chk("rst_wc2", 32'(wc2), 32'(0));

    // Release with strobes idle: outputs stay 0.
    idle();
    gnt1  = 1'b0;
    gnt2  = 1'b0;
    rst_n = 1'b1;
    step();
    chk("rel_smp_gnt", 32'(smp_gnt), 32'(0));
    chk("rel_rise", 32'(gnt_rise), 32'(0));
    chk("rel_wc0", 32'(wc0), 32'(0));

    // Instance 0: request with zero latency, responder echoes req.
    resp0 = 1'b1;
    drive(0, 1'b1, 1'b1, 1'b0);
    step();
    idle();
    chk("lat_wc0_n", 32'(wc0), 32'(0));
    step();
    chk("lat_smp_gnt_n1", 32'(smp_gnt[0]), 32'(0));
    chk("lat_wc0_n1", 32'(wc0), 32'(1));
    step();
    chk("lat_smp_gnt_n2", 32'(smp_gnt[0]), 32'(1));
    chk("lat_rise_n2", 32'(gnt_rise[0]), 32'(1));
    chk("lat_wc0_n2", 32'(wc0), 32'(2));
    step();
    chk("lat_rise_n3", 32'(gnt_rise[0]), 32'(0));
    chk("lat_wc0_n3", 32'(wc0), 32'(0));

    // Drop req and follow the grant falling edge.
    drive(0, 1'b1, 1'b0, 1'b0);
    step();
    idle();
    step();
    chk("drop_smp_gnt", 32'(smp_gnt[0]), 32'(1));
    chk("drop_fall_early", 32'(gnt_fall[0]), 32'(0));
    step();
    chk("drop_smp_gnt_lo", 32'(smp_gnt[0]), 32'(0));
    chk("drop_fall", 32'(gnt_fall[0]), 32'(1));
    chk("drop_rise", 32'(gnt_rise[0]), 32'(0));
    step();
    chk("drop_fall_end", 32'(gnt_fall[0]), 32'(0));

    // Both strobes with drv_req=0 while req=0: value strobe wins, req stays 0.
    drive(0, 1'b1, 1'b0, 1'b1);
    step();
    idle();
    step();
    chk("both_req0", 32'(req[0]), 32'(0));

    // Timeout: gnt held 0, req=1, counter saturates at 15.
    resp0 = 1'b0;
    drive(0, 1'b1, 1'b1, 1'b0);
    step();
    idle();
    chk("to_wc0_start", 32'(wc0), 32'(0));
    for (int j = 1; j <= 20; j++) begin
      step();
      e = (j > 15) ? 15 : j;
      chk($sformatf("to_wc0_%0d", j), 32'(wc0), 32'(e));
      chk($sformatf("to_flag_%0d", j), 32'(timeout[0]), 32'(e >= 10));
    end
    drive(0, 1'b1, 1'b0, 1'b0);
    step();
    idle();
    chk("to_wc0_hold", 32'(wc0), 32'(15));
    chk("to_flag_hold", 32'(timeout[0]), 32'(1));
    step();
    chk("to_wc0_clr", 32'(wc0), 32'(0));
    chk("to_flag_clr", 32'(timeout[0]), 32'(0));

    // Instance 1: toggle every 3rd edge with a 2-cycle output lag.
    for (int i = 0; i < 12; i++) begin
      if (i % 3 == 0) drive(1, 1'b0, 1'b0, 1'b1);
      step();
      idle();
    end
    repeat (3) step();
    chk("tog_req1_final", 32'(req[1]), 32'(0));

    // Instance 2: two-stage gnt sampling.
    gnt2 = 1'b1;
    step();
    chk("sync2_smp_e1", 32'(smp_gnt[2]), 32'(0));
    step();
    chk("sync2_smp_e2", 32'(smp_gnt[2]), 32'(1));
    chk("sync2_rise", 32'(gnt_rise[2]), 32'(1));
    gnt2 = 1'b0;
    step();
    chk("sync2_smp_f1", 32'(smp_gnt[2]), 32'(1));
    chk("sync2_fall_f1", 32'(gnt_fall[2]), 32'(0));
    step();
    chk("sync2_smp_f2", 32'(smp_gnt[2]), 32'(0));
    chk("sync2_fall_f2", 32'(gnt_fall[2]), 32'(1));

    // Instance 2: reset mid-pipeline discards the pending command.
    drive(2, 1'b1, 1'b1, 1'b0);
    step();
    idle();
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (4) step();
    chk("midrst_req2", 32'(req[2]), 32'(0));
    chk("midrst_smp_req2", 32'(smp_req[2]), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
